// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module      : icache
//  Description : Direct-mapped, read-only instruction cache. Serves a
//                four-phase fetch handshake from an internal line store and
//                refills whole lines, one word per four-phase memory
//                handshake, on a miss. A flush pulse invalidates all lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [DATA_WIDTH-1:0] inst_addr,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  flush
);

  localparam int TAG_BITS = DATA_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << (INDEX_BITS + OFFSET_BITS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_MEM_REQ  = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_RESP     = 3'd4,
    S_FLUSH    = 3'd5
  } state_t;

  state_t state;

  // Captured request address; the transaction never looks at inst_addr again.
  logic [DATA_WIDTH-1:0]  req_addr;
  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_index;
  logic [OFFSET_BITS-1:0] req_offset;

  // Line store: valid bits are reset/flushed, tags and data are not.
  logic [LINES-1:0]       valid_bits;
  logic [TAG_BITS-1:0]    tag_mem  [LINES];
  logic [DATA_WIDTH-1:0]  data_mem [WORDS];

  logic [OFFSET_BITS-1:0] cnt;
  logic [OFFSET_BITS-1:0] next_cnt;
  logic                   flush_pend;

  logic                   hit;
  logic                   fill_we;
  logic                   line_done;
  logic                   tag_we;
  logic [DATA_WIDTH-1:0]  hit_word;

  assign req_tag    = req_addr[DATA_WIDTH-1 -: TAG_BITS];
  assign req_index  = req_addr[OFFSET_BITS +: INDEX_BITS];
  assign req_offset = req_addr[OFFSET_BITS-1:0];

  assign hit      = valid_bits[req_index] && (tag_mem[req_index] == req_tag);
  assign hit_word = data_mem[{req_index, req_offset}];
  assign next_cnt = cnt + 1'b1;

  // A word is written when memory answers the outstanding request; the tag is
  // written only once the final word's handshake has fully closed.
  assign fill_we   = !rst && (state == S_MEM_REQ) && mem_valid;
  assign line_done = (cnt == {OFFSET_BITS{1'b1}});
  assign tag_we    = !rst && (state == S_MEM_WAIT) && !mem_valid && line_done;

  // Unreset line storage: refill data words and line tags.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[{req_index, cnt}] <= mem_data;
    end
    if (tag_we) begin
      tag_mem[req_index] <= req_tag;
    end
  end

  // Flush pending flag: any pulse is remembered until S_FLUSH services it;
  // a pulse coinciding with the service cycle re-arms the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pend <= 1'b0;
    end else if (state == S_FLUSH) begin
      flush_pend <= flush;
    end else if (flush) begin
      flush_pend <= 1'b1;
    end
  end

  // Main controller with registered handshake outputs and valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_addr   <= '0;
      cnt        <= '0;
      valid_bits <= '0;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush_pend) begin
            state <= S_FLUSH;
          end else if (inst_req) begin
            req_addr <= inst_addr;
            state    <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (hit) begin
            inst_data  <= hit_word;
            inst_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            // Refill always starts at offset 0 of the missing line.
            cnt      <= '0;
            mem_req  <= 1'b1;
            mem_addr <= {req_tag, req_index, {OFFSET_BITS{1'b0}}};
            state    <= S_MEM_REQ;
          end
        end

        S_MEM_REQ: begin
          if (mem_valid) begin
            mem_req <= 1'b0;
            state   <= S_MEM_WAIT;
          end
        end

        S_MEM_WAIT: begin
          if (!mem_valid) begin
            if (line_done) begin
              valid_bits[req_index] <= 1'b1;
              state                 <= S_LOOKUP;
            end else begin
              // Offset field is built from cnt, so the address never carries
              // into index or tag.
              cnt      <= next_cnt;
              mem_req  <= 1'b1;
              mem_addr <= {req_tag, req_index, next_cnt};
              state    <= S_MEM_REQ;
            end
          end
        end

        S_RESP: begin
          if (!inst_req) begin
            inst_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end

        S_FLUSH: begin
          valid_bits <= '0;
          state      <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the fetch stage and the instruction memory bus. It serves fetch's word-addressed four-phase request/valid handshake (`inst_req`/`inst_valid`) from an internal line store. On a miss it refills the whole line from memory, one word per four-phase memory handshake, then answers fetch. A flush input invalidates all lines, for reset-time program loading or self-modifying code.

## Interface
- `DATA_WIDTH`, 32: address and instruction width. Addresses are word addresses.
- `INDEX_BITS`, 4: number of lines is 2^INDEX_BITS.
- `OFFSET_BITS`, 2: words per line is 2^OFFSET_BITS.
- Derived `TAG_BITS` = DATA_WIDTH - INDEX_BITS - OFFSET_BITS. The address splits as {tag, index, offset}, MSB to LSB.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_req`  in  1  fetch request, level.
- `inst_addr`  in  DATA_WIDTH  fetch word address; valid while `inst_req`=1.
- `inst_valid`  out  1  response valid, level.
- `inst_data`  out  DATA_WIDTH  instruction; registered and held until the next response.
- `mem_req`  out  1  memory word request, level.
- `mem_addr`  out  DATA_WIDTH  memory word address.
- `mem_valid`  in  1  memory response, level.
- `mem_data`  in  DATA_WIDTH  memory word; valid while `mem_valid`=1.
- `flush`  in  1  invalidate all lines; single-cycle pulse.

## Operation
- Storage:
  - valid bit and tag per line, in registers.
  - data array of 2^(INDEX_BITS+OFFSET_BITS) words, read combinationally.
- Request register: `inst_addr` is captured when a request is accepted and is used for the rest of the transaction.
- S_IDLE:
  - If a flush is pending → S_FLUSH.
  - Else if `inst_req`=1 → capture address, → S_LOOKUP.
- S_LOOKUP: hit = valid[index] && tag[index]==tag.
  - Hit: load `inst_data` with data[index][offset], → S_RESP.
  - Miss: clear refill counter `cnt` (OFFSET_BITS wide), → S_MEM_REQ.
- S_MEM_REQ:
  - `mem_req`=1, `mem_addr`={tag, index, cnt}.
  - On `mem_valid`=1: write `mem_data` into data[index][cnt], → S_MEM_WAIT.
- S_MEM_WAIT:
  - `mem_req`=0; wait for `mem_valid`=0.
  - Then, if cnt == all-ones: set valid[index]=1 and tag[index]=tag, → S_LOOKUP (guaranteed hit).
  - Else: cnt+1, → S_MEM_REQ.
- Refill order is always offset 0 to last, not critical-word-first.
- S_RESP:
  - `inst_valid`=1.
  - When `inst_req`=0 is sampled → S_IDLE; `inst_valid` falls the following cycle.
- S_FLUSH: clear all valid bits in one cycle, clear pending flag, → S_IDLE.
- Flush:
  - A `flush` pulse in any state sets the pending flag. It is never lost and never aborts a refill or response.
  - A pulse arriving in the same cycle S_FLUSH clears the flag keeps the flag set.
- An accepted request is committed: `inst_addr` or `inst_req` changes after acceptance are ignored until S_RESP.
- `mem_req` and `inst_valid` are driven from registered state, so there is no combinational path from the input handshakes.

## Timing
- Reset, effective the cycle after `rst` is sampled high:
  - state S_IDLE.
  - `inst_valid`=0, `inst_data`=0.
  - `mem_req`=0, `mem_addr`=0.
  - all valid bits 0, flush pending 0.
- Reset mid-refill: the line stays invalid and partial words are don't-care.
- Hit: `inst_req` first sampled high at edge E0; S_LOOKUP in the cycle after E0; `inst_valid`=1 two cycles after `inst_req` rises.
- Miss: 1 (lookup) + 2^OFFSET_BITS × (memory handshake) + 1 (re-lookup) cycles, then `inst_valid`.
  - Memory handshake, minimum 2 cycles per word with zero-latency memory.
- `inst_data` is stable from `inst_valid` rise through the cycle after `inst_valid` falls, and beyond until the next S_LOOKUP hit. Fetch samples it in that trailing cycle.
- `mem_addr` is stable while `mem_req`=1 and during S_MEM_WAIT.
- Address wrap: `{tag, index, cnt}` never carries into tag; an address of all ones refills its own line only.

## Test plan
- Cold miss: reset, request 0x00000005; memory returns data = addr ^ 0xA5A50000.
  - Required: `mem_addr` sequence 4, 5, 6, 7, one four-phase handshake each.
  - Then `inst_valid`=1 with `inst_data`=0xA5A50005.
- Hit: after the cold miss, request 0x00000006.
  - Required: `inst_valid` two cycles after the request, `inst_data`=0xA5A50006, `mem_req` stays 0.
- Conflict: request 0x45 (same index 1, different tag), then 0x05.
  - Required: refill of 0x44..0x47, then a full refill of 0x04..0x07.
  - Responses 0xA5A50045 and 0xA5A50005.
- Flush: pulse `flush` while in S_RESP for 0x05, then request 0x06.
  - Required: response to 0x05 completes normally; S_FLUSH occurs; 0x06 misses and refills 4..7.
- Reset mid-refill: assert `rst` after 2 refill words.
  - Required: next cycle `mem_req`=0, `inst_valid`=0, `inst_data`=0.
  - Re-request 0x05: four-word refill, correct data.
- Fetch integration: connect to the fetch stage with START_ADDR 0 and memory `mem_valid` delayed 3 cycles.
  - Required: sequential instructions 0..9 delivered in order, and lines 0–2 each refilled exactly once.
